// File: rtl/mlaccel_pkg.sv
// Shared constants for the mlaccel SPI front end: opcodes, byte widths, PHY states.
package mlaccel_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Command opcodes carried in the first byte of each SPI frame
  localparam logic [BYTE_W-1:0] OP_STATUS    = 8'h20;
  localparam logic [BYTE_W-1:0] OP_WRITE_BUF = 8'h21;
  localparam logic [BYTE_W-1:0] OP_READ_BUF  = 8'h22;
  localparam logic [BYTE_W-1:0] OP_STORE     = 8'h23;
  localparam logic [BYTE_W-1:0] OP_LOAD      = 8'h24;
  localparam logic [BYTE_W-1:0] OP_RUN       = 8'h25;

  // Byte shifted out on MISO when nothing is buffered
  localparam logic [BYTE_W-1:0] IDLE_BYTE_DEF = 8'h00;

  // Frame state, keyed on the synchronised chip select
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

endpackage

// File: rtl/mlaccel_sync.sv
// Single-bit multi-flop synchroniser with synchronous reset to a chosen level.
module mlaccel_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw pin one stage deeper each clock
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser flops
  always_ff @(posedge clock) begin
    if (reset) sync_q <= {STAGES{RST_VAL}};
    else       sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/mlaccel_spi_phy.sv
// SPI mode-3 slave PHY: oversampled pins, MOSI deserialiser, one-deep tx buffer, MISO serialiser.
module mlaccel_spi_phy
  import mlaccel_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_csb,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_first,
  output logic              xfer_end,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_underrun
);

  logic csb_s, sclk_s, mosi_s;

  // Pin synchronisers; csb resets low so a frame already in progress is never seen as starting
  mlaccel_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_csb (
    .clock(clock), .reset(reset), .d(spi_csb), .q(csb_s)
  );
  mlaccel_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_clk (
    .clock(clock), .reset(reset), .d(spi_clk), .q(sclk_s)
  );
  mlaccel_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .d(spi_mosi), .q(mosi_s)
  );

  logic [0:0]           state_q,      state_d;
  logic                 csb_prev_q,   csb_prev_d;
  logic                 sclk_prev_q,  sclk_prev_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
  logic [BYTE_W-1:0]    rx_shift_q,   rx_shift_d;
  logic                 byte_done_q,  byte_done_d;
  logic                 first_flag_q, first_flag_d;
  logic                 end_pend_q,   end_pend_d;
  logic [BYTE_W-1:0]    tx_shift_q,   tx_shift_d;
  logic [BYTE_W-1:0]    tx_buf_q,     tx_buf_d;
  logic                 tx_full_q,    tx_full_d;
  logic                 spi_miso_q,   spi_miso_d;
  logic                 rx_valid_q,   rx_valid_d;
  logic [BYTE_W-1:0]    rx_data_q,    rx_data_d;
  logic                 rx_first_q,   rx_first_d;
  logic                 xfer_end_q,   xfer_end_d;
  logic                 tx_ready_q,   tx_ready_d;
  logic                 tx_underrun_q, tx_underrun_d;

  logic csb_fall, csb_rise, clk_rise, tx_wr, load_tx;

  // Next-state logic: edge detection, shifting, byte boundary handling and tx buffer
  always_comb begin
    state_d       = state_q;
    csb_prev_d    = csb_s;
    sclk_prev_d   = sclk_s;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    byte_done_d   = 1'b0;
    first_flag_d  = first_flag_q;
    end_pend_d    = 1'b0;
    tx_shift_d    = tx_shift_q;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    rx_valid_d    = 1'b0;
    rx_data_d     = rx_data_q;
    rx_first_d    = 1'b0;
    xfer_end_d    = end_pend_q;
    tx_underrun_d = 1'b0;
    load_tx       = 1'b0;

    csb_fall = csb_prev_q & ~csb_s;
    csb_rise = ~csb_prev_q & csb_s;
    clk_rise = (state_q == ST_ACTIVE) & ~csb_s & sclk_s & ~sclk_prev_q;
    tx_wr    = tx_valid & tx_ready_q;

    if (tx_wr) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (csb_fall) begin
          state_d      = ST_ACTIVE;
          bit_cnt_d    = '0;
          first_flag_d = 1'b1;
          load_tx      = 1'b1;
        end
      end
      default: begin
        // A completed byte is always delivered, even if csb rises in the same cycle
        if (byte_done_q) begin
          rx_valid_d   = 1'b1;
          rx_data_d    = rx_shift_q;
          rx_first_d   = first_flag_q;
          first_flag_d = 1'b0;
        end
        if (csb_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          if (byte_done_q) end_pend_d = 1'b1;
          else             xfer_end_d = 1'b1;
        end else begin
          if (byte_done_q) begin
            load_tx       = 1'b1;
            tx_underrun_d = ~tx_full_q;
          end
          if (clk_rise) begin
            rx_shift_d  = {rx_shift_q[BYTE_W-2:0], mosi_s};
            tx_shift_d  = {tx_shift_q[BYTE_W-2:0], 1'b0};
            bit_cnt_d   = BIT_CNT_W'(bit_cnt_q + BIT_CNT_W'(1));
            byte_done_d = (bit_cnt_q == BIT_CNT_W'(7));
          end
        end
      end
    endcase

    // Buffered byte goes out next; a write landing in the same cycle refills the buffer
    if (load_tx) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = tx_wr;
      end else begin
        tx_shift_d = IDLE_BYTE;
      end
    end

    tx_ready_d = ~tx_full_d;
    spi_miso_d = (state_d == ST_ACTIVE) ? tx_shift_d[BYTE_W-1] : 1'b0;
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      csb_prev_q    <= 1'b0;
      sclk_prev_q   <= 1'b1;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      byte_done_q   <= 1'b0;
      first_flag_q  <= 1'b0;
      end_pend_q    <= 1'b0;
      tx_shift_q    <= '0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      spi_miso_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      rx_first_q    <= 1'b0;
      xfer_end_q    <= 1'b0;
      tx_ready_q    <= 1'b1;
      tx_underrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      csb_prev_q    <= csb_prev_d;
      sclk_prev_q   <= sclk_prev_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      byte_done_q   <= byte_done_d;
      first_flag_q  <= first_flag_d;
      end_pend_q    <= end_pend_d;
      tx_shift_q    <= tx_shift_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      spi_miso_q    <= spi_miso_d;
      rx_valid_q    <= rx_valid_d;
      rx_data_q     <= rx_data_d;
      rx_first_q    <= rx_first_d;
      xfer_end_q    <= xfer_end_d;
      tx_ready_q    <= tx_ready_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign spi_miso    = spi_miso_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign rx_first    = rx_first_q;
  assign xfer_end    = xfer_end_q;
  assign tx_ready    = tx_ready_q;
  assign tx_underrun = tx_underrun_q;

endmodule
